// File: rtl/decomp_pkg.sv
// Shared types and constants for the run-length decompressor DMA controller.
package decomp_pkg;

    // Data path width; matches the decompressor Din/Dout.
    localparam int DATA_W     = 16;
    // Default widths for memory addresses and frame lengths.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 16;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/decomp_prefetch_buf.sv
// One-entry prefetch buffer between the memory read port and the decompressor feeder.
// A push while full is only legal together with a pop; the pushed word then replaces
// the popped one in the same cycle.
module decomp_prefetch_buf
    import decomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state of the single entry: flush wins, then pop, then push.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else begin
            if (pop_i && valid_q) begin
                valid_d = 1'b0;
            end
            if (push_i) begin
                valid_d = 1'b1;
                data_d  = push_data_i;
            end
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/decomp_dma_ctrl.sv
// DMA sequencer for the run-length decompressor: fetches compressed words from memory,
// feeds them through the load/done handshake and writes every completed output word
// to the destination buffer. Pulses irq at the end of each frame.
module decomp_dma_ctrl
    import decomp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [LEN_W-1:0]  src_len_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [LEN_W-1:0]  out_len_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_valid_i,
    output logic              dec_restart_o,
    output logic              dec_load_o,
    output logic [DATA_W-1:0] dec_din_o,
    input  logic              dec_done_i,
    input  logic              dec_out_valid_i,
    input  logic [DATA_W-1:0] dec_dout_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              irq_o,
    output logic              err_o
);

    // FSM and control-status registers
    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic              dec_restart_q, dec_restart_d;
    logic              cfg_load;

    // Latched frame configuration
    logic [ADDR_W-1:0] src_base_q, src_base_d;
    logic [LEN_W-1:0]  src_len_q, src_len_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;

    // Fetcher, feeder and writer state
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  fed_cnt_q, fed_cnt_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              rd_out_q, rd_out_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              dec_load_q, dec_load_d;
    logic [DATA_W-1:0] dec_din_q, dec_din_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Prefetch buffer interface
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_flush;

    // Derived conditions
    logic              run;
    logic              wr_done;
    logic              src_exh;
    logic              active;
    logic              rd_issue;
    logic              wr_take;

    assign run      = (state_q == ST_RUN);
    assign wr_done  = (wr_cnt_q == out_len_q);
    assign src_exh  = (fed_cnt_q == src_len_q);
    // Loading and fetching stop as soon as the last output word has been written.
    assign active   = run && !wr_done;
    // Hand the buffered word over when no word is loaded or the loaded one is consumed now.
    assign buf_pop  = active && buf_valid && (!dec_load_q || dec_done_i);
    // Late read data outside RUN is absorbed and dropped.
    assign buf_push = run && rd_valid_i && rd_out_q;
    assign buf_flush = !run;
    // One read in flight, and only when the buffer is guaranteed free on return.
    assign rd_issue = active && !rd_out_q && (rd_cnt_q < src_len_q) && (!buf_valid || buf_pop);
    assign wr_take  = run && dec_out_valid_i && !wr_done;

    decomp_prefetch_buf u_prefetch_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (buf_flush),
        .push_i      (buf_push),
        .push_data_i (rd_data_i),
        .pop_i       (buf_pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data)
    );

    // Frame FSM: next state, status flags and configuration capture.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        irq_d         = 1'b0;
        err_d         = err_q;
        dec_restart_d = 1'b0;
        cfg_load      = 1'b0;
        src_base_d    = src_base_q;
        src_len_d     = src_len_q;
        dst_base_d    = dst_base_q;
        out_len_d     = out_len_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cfg_load   = 1'b1;
                    src_base_d = src_base_i;
                    src_len_d  = src_len_i;
                    dst_base_d = dst_base_i;
                    out_len_d  = out_len_i;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (out_len_i == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d       = ST_INIT;
                        dec_restart_d = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wr_done) begin
                    state_d = ST_FINISH;
                end else if (src_exh) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // Hold here until any in-flight read has returned so IDLE starts clean.
                if (!rd_out_q) begin
                    irq_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetcher, feeder and writer datapath next-state.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        fed_cnt_d  = fed_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_out_d   = rd_out_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        dec_load_d = dec_load_q;
        dec_din_d  = dec_din_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (cfg_load) begin
            rd_cnt_d  = '0;
            fed_cnt_d = '0;
            wr_cnt_d  = '0;
        end

        if (rd_valid_i) begin
            rd_out_d = 1'b0;
        end
        if (rd_issue) begin
            rd_out_d  = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = src_base_q + ADDR_W'(rd_cnt_q);
            rd_cnt_d  = rd_cnt_q + LEN_W'(1);
        end

        if (run && dec_load_q && dec_done_i) begin
            fed_cnt_d = fed_cnt_q + LEN_W'(1);
        end

        if (!active) begin
            dec_load_d = 1'b0;
        end else if (buf_pop) begin
            dec_load_d = 1'b1;
            dec_din_d  = buf_data;
        end else if (dec_done_i) begin
            dec_load_d = 1'b0;
        end

        if (wr_take) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_base_q + ADDR_W'(wr_cnt_q);
            wr_data_d = dec_dout_i;
            wr_cnt_d  = wr_cnt_q + LEN_W'(1);
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            irq_q         <= 1'b0;
            err_q         <= 1'b0;
            dec_restart_q <= 1'b0;
            src_base_q    <= '0;
            src_len_q     <= '0;
            dst_base_q    <= '0;
            out_len_q     <= '0;
            rd_cnt_q      <= '0;
            fed_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            rd_out_q      <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            dec_load_q    <= 1'b0;
            dec_din_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            irq_q         <= irq_d;
            err_q         <= err_d;
            dec_restart_q <= dec_restart_d;
            src_base_q    <= src_base_d;
            src_len_q     <= src_len_d;
            dst_base_q    <= dst_base_d;
            out_len_q     <= out_len_d;
            rd_cnt_q      <= rd_cnt_d;
            fed_cnt_q     <= fed_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_out_q      <= rd_out_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            dec_load_q    <= dec_load_d;
            dec_din_q     <= dec_din_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign rd_en_o       = rd_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign dec_restart_o = dec_restart_q;
    assign dec_load_o    = dec_load_q;
    assign dec_din_o     = dec_din_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign busy_o        = busy_q;
    assign irq_o         = irq_q;
    assign err_o         = err_q;

endmodule
